// File: rtl/esd_pkg.sv
// Shared definitions for the emergency-shutdown restart path: sequencer
// state encoding, timing defaults and channel-count limits.
package esd_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_STEP_WAIT = 3'd1,
        SEQ_CONFIRM   = 3'd2,
        SEQ_RUNNING   = 3'd3,
        SEQ_FAULT     = 3'd4
    } seq_state_t;

    localparam int CLK_FREQ_HZ        = 50_000_000;
    localparam int DEF_STEP_CYCLES    = 50_000;
    localparam int DEF_CONFIRM_CYCLES = 25_000;
    localparam int MAX_CH             = 8;
    localparam int CH_W               = 3;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic logic [CH_W-1:0] lowest_set(input logic [MAX_CH-1:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CH_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/actuator_restart_seq_timer.sv
// Loadable down-counter shared by the step-delay and confirm-window intervals.
// It holds at zero rather than wrapping.
module seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/actuator_restart_seq.sv
// Staged actuator re-enable sequencer: enables channels one at a time after a
// start, waits for each channel's feedback, and latches a fault on timeout or loss.
module actuator_restart_seq
    import esd_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int STEP_CYCLES    = DEF_STEP_CYCLES,
    parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shutdown_in,
    input  logic            start,
    input  logic            clr,
    input  logic [N_CH-1:0] fb_ok,
    output logic [N_CH-1:0] en_out,
    output logic            busy,
    output logic            ready,
    output logic            fault,
    output logic [2:0]      fault_ch
);

    localparam int MAX_CYC = (STEP_CYCLES > CONFIRM_CYCLES) ? STEP_CYCLES : CONFIRM_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] STEP_LOAD    = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONFIRM_LOAD = CNT_W'(CONFIRM_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'(SEQ_IDLE);
    localparam logic [2:0] ST_STEP_WAIT = 3'(SEQ_STEP_WAIT);
    localparam logic [2:0] ST_CONFIRM   = 3'(SEQ_CONFIRM);
    localparam logic [2:0] ST_RUNNING   = 3'(SEQ_RUNNING);
    localparam logic [2:0] ST_FAULT     = 3'(SEQ_FAULT);

    logic [2:0]      state_q,    state_d;
    logic [N_CH-1:0] en_q,       en_d;
    logic [CH_W-1:0] ch_q,       ch_d;
    logic [CH_W-1:0] fault_ch_q, fault_ch_d;

    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Per-channel decode of the current step and of the already-confirmed set.
    logic [N_CH-1:0] ch_onehot;
    logic [N_CH-1:0] confirmed;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign ch_onehot[gi] = (ch_q == CH_W'(gi));
        assign confirmed[gi] = (state_q == ST_RUNNING) || (CH_W'(gi) < ch_q);
    end

    logic            health_active;
    logic [N_CH-1:0] lost_mask;
    logic            lost_any;
    logic [CH_W-1:0] lost_idx;
    logic            fb_cur;
    logic            ch_last;

    assign health_active = (state_q == ST_STEP_WAIT) || (state_q == ST_CONFIRM) ||
                           (state_q == ST_RUNNING);
    assign lost_mask     = confirmed & ~fb_ok & {N_CH{health_active}};
    assign lost_any      = |lost_mask;
    assign lost_idx      = lowest_set(MAX_CH'(lost_mask));
    assign fb_cur        = |(fb_ok & ch_onehot);
    assign ch_last       = (ch_q == CH_W'(N_CH - 1));

    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        ch_d         = ch_q;
        fault_ch_d   = fault_ch_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_load_val = '0;

        if (shutdown_in) begin
            // A latched fault survives shutdown; anything else drops back to IDLE.
            if (state_q != ST_FAULT) begin
                state_d = ST_IDLE;
                en_d    = '0;
                ch_d    = '0;
            end
        end else if (lost_any) begin
            state_d    = ST_FAULT;
            en_d       = '0;
            fault_ch_d = lost_idx;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d      = ST_STEP_WAIT;
                        ch_d         = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = STEP_LOAD;
                    end
                end
                ST_STEP_WAIT: begin
                    if (tmr_zero) begin
                        state_d      = ST_CONFIRM;
                        en_d         = en_q | ch_onehot;
                        tmr_load     = 1'b1;
                        tmr_load_val = CONFIRM_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (fb_cur) begin
                        if (ch_last) begin
                            state_d = ST_RUNNING;
                        end else begin
                            state_d      = ST_STEP_WAIT;
                            ch_d         = ch_q + CH_W'(1);
                            tmr_load     = 1'b1;
                            tmr_load_val = STEP_LOAD;
                        end
                    end else if (tmr_zero) begin
                        state_d    = ST_FAULT;
                        en_d       = '0;
                        fault_ch_d = ch_q;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_RUNNING: begin
                end
                ST_FAULT: begin
                    if (clr) begin
                        state_d    = ST_IDLE;
                        ch_d       = '0;
                        fault_ch_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    en_d    = '0;
                    ch_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= '0;
            ch_q       <= '0;
            fault_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            ch_q       <= ch_d;
            fault_ch_q <= fault_ch_d;
        end
    end

    // Shutdown must cut the enables within the same cycle, ahead of any register.
    assign en_out   = en_q & ~{N_CH{shutdown_in}};
    assign busy     = (state_q == ST_STEP_WAIT) || (state_q == ST_CONFIRM);
    assign ready    = (state_q == ST_RUNNING);
    assign fault    = (state_q == ST_FAULT);
    assign fault_ch = fault_ch_q;

endmodule

// File: tb/tb_actuator_restart_seq.sv
// Scoreboard bench for actuator_restart_seq: stimulus queues expected output
// changes with their edge numbers, a monitor matches them as the DUT moves.
module tb_actuator_restart_seq;

    localparam int N    = 4;
    localparam int STEP = 100;
    localparam int CONF = 20;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b1;
    logic         shutdown_in = 1'b0;
    logic         start       = 1'b0;
    logic         clr         = 1'b0;
    logic [N-1:0] fb_ok       = '0;
    logic [N-1:0] en_out;
    logic         busy;
    logic         ready;
    logic         fault;
    logic [2:0]   fault_ch;

    actuator_restart_seq #(
        .N_CH           (N),
        .STEP_CYCLES    (STEP),
        .CONFIRM_CYCLES (CONF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .shutdown_in (shutdown_in),
        .start       (start),
        .clr         (clr),
        .fb_ok       (fb_ok),
        .en_out      (en_out),
        .busy        (busy),
        .ready       (ready),
        .fault       (fault),
        .fault_ch    (fault_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [9:0] v;
    } ev_t;

    typedef struct {
        string      name;
        logic [9:0] v;
    } pr_t;

    ev_t exp_q[$];
    pr_t probe_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  done  = 1'b0;
    int  ev_n  = 0;

    function automatic logic [9:0] mk(input logic [3:0] en, input logic b, input logic r,
                                      input logic f, input logic [2:0] fc);
        return {en, b, r, f, fc};
    endfunction

    task automatic push_ev(input int c, input logic [9:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic probe(input string name, input logic [9:0] v);
        pr_t p;
        p.name = name;
        p.v    = v;
        probe_q.push_back(p);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a sequence; fb_ok[k] is sampled high 5 edges after en_out[k] rises,
    // except for bad_ch which never confirms. poke adds ignored start pulses.
    task automatic run_seq(input int bad_ch, input bit poke);
        int         ts;
        int         tk;
        logic [3:0] m;
        ts = cyc + 1;
        push_ev(ts, mk(4'h0, 1'b1, 1'b0, 1'b0, 3'd0));
        start = 1'b1;
        run_to(ts);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            tk = ts + STEP + (STEP + 5) * k;
            m  = 4'((1 << (k + 1)) - 1);
            push_ev(tk, mk(m, 1'b1, 1'b0, 1'b0, 3'd0));
            if (k == bad_ch) begin
                push_ev(tk + CONF, mk(4'h0, 1'b0, 1'b0, 1'b1, 3'(k)));
                run_to(tk + CONF + 1);
                return;
            end
            if (poke && k == 0) begin
                run_to(ts + 49);
                start = 1'b1;
                run_to(ts + 50);
                start = 1'b0;
            end
            run_to(tk + 4);
            fb_ok[k] = 1'b1;
        end
        push_ev(ts + N * (STEP + 5), mk(4'hF, 1'b0, 1'b1, 1'b0, 3'd0));
        run_to(ts + N * (STEP + 5) + 1);
        if (poke) begin
            start = 1'b1;
            run_to(cyc + 1);
            start = 1'b0;
            run_to(cyc + 10);
        end
    endtask

    // One-cycle shutdown from RUNNING: enables drop in-cycle, IDLE at the next edge.
    task automatic shut_pulse();
        int e;
        e = cyc;
        push_ev(e, mk(4'h0, 1'b0, 1'b1, 1'b0, 3'd0));
        push_ev(e + 1, 10'h000);
        shutdown_in = 1'b1;
        run_to(e + 1);
        shutdown_in = 1'b0;
    endtask

    task automatic clr_fault();
        int e;
        e = cyc;
        push_ev(e + 1, 10'h000);
        clr = 1'b1;
        run_to(e + 1);
        clr = 1'b0;
    endtask

    initial begin : monitor
        logic [9:0] prev;
        logic [9:0] cur;
        ev_t        e;
        pr_t        p;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {en_out, busy, ready, fault, fault_ch};
            if (cur !== prev) begin
                total++;
                ev_n++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d vec=%h, required no change from %h",
                             cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.v || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL ev%0d: got cyc=%0d vec=%h, required cyc=%0d vec=%h",
                                 ev_n, cyc, cur, e.cyc, e.v);
                    end else begin
                        $display("ev%0d ok: cyc=%0d vec=%h", ev_n, cyc, cur);
                    end
                end
                prev = cur;
            end
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                total++;
                if (cur !== p.v) begin
                    bad++;
                    $display("FAIL %s: got vec=%h, required %h", p.name, cur, p.v);
                end else begin
                    $display("%s ok: cyc=%0d vec=%h", p.name, cyc, cur);
                end
            end
            if (done || cyc > 20000) begin
                if (!done) begin
                    total++;
                    bad++;
                    $display("FAIL watchdog: cyc=%0d, required stimulus completion", cyc);
                end
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin : stim
        int ts;
        #2 rst_n = 1'b0;
        probe("reset_state", 10'h000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_to(cyc + 2);

        // Nominal staged enable.
        run_seq(-1, 1'b0);

        // Shutdown pulse in RUNNING, then replay.
        shut_pulse();
        fb_ok = '0;
        run_seq(-1, 1'b0);

        // Feedback loss in RUNNING; clear is ignored while shutdown is high.
        begin
            int e;
            e = cyc;
            push_ev(e + 1, mk(4'h0, 1'b0, 1'b0, 1'b1, 3'd1));
            fb_ok[1] = 1'b0;
            run_to(e + 2);
            shutdown_in = 1'b1;
            clr         = 1'b1;
            run_to(e + 3);
            clr = 1'b0;
            run_to(e + 4);
            shutdown_in = 1'b0;
            run_to(e + 5);
            push_ev(e + 6, 10'h000);
            clr = 1'b1;
            run_to(e + 6);
            clr = 1'b0;
        end
        fb_ok = '0;

        // Channel 2 never confirms: timeout fault, then clear.
        run_seq(2, 1'b0);
        fb_ok = '0;
        clr_fault();

        // Stray start pulses must not disturb the sequence.
        run_seq(-1, 1'b1);
        shut_pulse();
        fb_ok = '0;

        // Asynchronous reset mid-CONFIRM of channel 1.
        ts = cyc + 1;
        push_ev(ts, mk(4'h0, 1'b1, 1'b0, 1'b0, 3'd0));
        push_ev(ts + STEP, mk(4'h1, 1'b1, 1'b0, 1'b0, 3'd0));
        push_ev(ts + 2 * STEP + 5, mk(4'h3, 1'b1, 1'b0, 1'b0, 3'd0));
        start = 1'b1;
        run_to(ts);
        start = 1'b0;
        run_to(ts + STEP + 4);
        fb_ok[0] = 1'b1;
        run_to(ts + 2 * STEP + 7);
        push_ev(ts + 2 * STEP + 7, 10'h000);
        probe("reset_async", 10'h000);
        rst_n = 1'b0;
        run_to(cyc + 2);
        fb_ok = '0;
        rst_n = 1'b1;
        probe("idle_after_reset", 10'h000);
        run_to(cyc + 2);
        run_seq(-1, 1'b0);

        run_to(cyc + 3);
        done = 1'b1;
    end

endmodule

// File: doc/actuator_restart_seq.md
# actuator_restart_seq

- Staged re-enable sequencer that sits downstream of the emergency-shutdown core.
- After shutdown is released and the operator issues a start, it enables `N_CH` actuator channels one at a time, in index order, with a fixed inter-step delay.
- Each enabled channel's feedback must confirm within a timeout before the next channel is enabled.
- `shutdown_in` gates every enable off in the same cycle it asserts.
- Any confirm timeout or loss of feedback latches a fault that only an explicit clear removes.

## Interface
Parameters:
- `N_CH`, 4: actuator channel count, 1..8.
- `STEP_CYCLES`, 50_000: delay from step start to channel enable, ≥1 (1 ms at 50 MHz).
- `CONFIRM_CYCLES`, 25_000: feedback confirm window per channel, ≥1.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `shutdown_in` in 1: active-high shutdown from the ESD core; highest priority.
- `start` in 1: one-cycle start request, honoured only in IDLE.
- `clr` in 1: one-cycle fault clear, honoured only in FAULT with `shutdown_in` low.
- `fb_ok` in N_CH: per-channel actuator-healthy feedback, already synchronised.
- `en_out` out N_CH: actuator enables, computed as `en_reg & ~{N_CH{shutdown_in}}`.
- `busy` out 1: high in STEP_WAIT or CONFIRM.
- `ready` out 1: high in RUNNING.
- `fault` out 1: high in FAULT.
- `fault_ch` out 3: index of the faulting channel; valid while `fault` is high.

## Operation
- States: IDLE, STEP_WAIT, CONFIRM, RUNNING, FAULT.
- Reset: state IDLE, `en_reg`=0, `ch`=0, counter=0, `fault_ch`=0. All outputs 0.
- Priority at every edge: `rst_n` > `shutdown_in` > fault detection > normal progress.
- `shutdown_in` high in any state except FAULT: `en_reg`←0, `ch`←0, next state IDLE, no fault recorded.
- `shutdown_in` high in FAULT: stay in FAULT.
- IDLE:
  - `start` with `shutdown_in` low → STEP_WAIT, `ch`←0, counter←STEP_CYCLES-1.
  - `start` in any other state is ignored.
- STEP_WAIT:
  - Decrement the counter each edge.
  - Counter observed 0 → `en_reg[ch]`←1, counter←CONFIRM_CYCLES-1, next state CONFIRM.
- CONFIRM:
  - `fb_ok[ch]` high → if `ch`==N_CH-1 go to RUNNING; else `ch`←ch+1, counter←STEP_CYCLES-1, next state STEP_WAIT.
  - Counter observed 0 with `fb_ok[ch]` low → FAULT, `fault_ch`←ch.
- Health check in STEP_WAIT, CONFIRM and RUNNING:
  - Any already-confirmed channel (index < `ch`, or all channels in RUNNING) with `fb_ok` low → FAULT.
  - `fault_ch`← lowest such index.
  - This check has priority over progress in the same cycle.
- On entry to FAULT: `en_reg`←0.
- FAULT: `clr` with `shutdown_in` low → IDLE, `fault_ch`←0.

## Timing
- `start` sampled at edge Ts → `en_out[0]` rises at edge Ts+STEP_CYCLES.
- `en_reg[k]` set at edge Tk:
  - `fb_ok[k]` is sampled at edges Tk+1 … Tk+CONFIRM_CYCLES.
  - If first seen high at Tk+c, `en_out[k+1]` rises at Tk+c+STEP_CYCLES.
- Timeout: no confirm by edge Tk+CONFIRM_CYCLES → `fault` high and `en_out`=0 after that edge.
- RUNNING is entered at the edge that samples `fb_ok[N_CH-1]` high; `ready` is high from that edge.
- `shutdown_in` → `en_out` is zero-cycle (combinational). State registers clear at the next edge.
- Feedback loss → `en_out` drops one edge after it is sampled.
- `rst_n` low clears all outputs asynchronously, including mid-CONFIRM.
- Counter width is `$clog2(max(STEP_CYCLES, CONFIRM_CYCLES))`; the counter never wraps, because it is reloaded on every state entry.

## Structure
- Shared package `esd_pkg`:
  - state enum `seq_state_t`.
  - `CLK_FREQ_HZ`=50_000_000.
  - default step and confirm constants.
  - maximum channel count of 8.
- One sub-module: `seq_timer`, a loadable down-counter with `load`, `value` and `zero` outputs, reused for both the step and confirm intervals.
- Everything else stays in the top-level FSM.

## Test plan
All scenarios use N_CH=4, STEP=100, CONFIRM=20, with `fb_ok[k]` driven high 5 cycles after `en_out[k]` rises unless stated otherwise.

1. Reset, then `start` at Ts → `en_out` bits rise at Ts+100, +205, +310, +415; `ready`=1 at Ts+420; `busy` low from Ts+420.
2. `fb_ok[2]` held low → `fault`=1 and `fault_ch`=2 at Ts+330 (T2+20); `en_out`=0 after that edge; `ready`=0.
3. `shutdown_in` pulsed for 1 cycle in RUNNING → `en_out`=0 in the same cycle, state IDLE, `fault`=0. A new `start` replays scenario 1 timing.
4. `fb_ok[1]` dropped in RUNNING → `fault_ch`=1 and `en_out`=0 one edge later. `clr` with `shutdown_in` high is ignored; `clr` with it low → IDLE.
5. `start` pulsed during STEP_WAIT and during RUNNING → no effect on sequence timing.
6. `rst_n` asserted mid-CONFIRM of channel 1 → all outputs 0 immediately, without waiting for a clock edge; after release the block is in IDLE.
